// File: rtl/pc2_pkg.sv
// rtl/pc2_pkg.sv - operation encodings for the pc2 program counter
package pc2_pkg;

  // Codes 6 and 7 are unassigned and fall through to HOLD in the decoder.
  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_JMP  = 3'd2,
    PC_BRA  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_op_e;

endpackage

// File: rtl/pc2_if.sv
// rtl/pc2_if.sv - fetch-stage bus between the fetch control and pc2
// Signals:
//   en, op, din, clr_err : driven by the fetch stage (master)
//   dout, ras_top, ras_cnt, ovf, unf : driven by pc2 (slave)
interface pc2_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic                     en;
  logic [2:0]               op;
  logic [WIDTH-1:0]         din;
  logic                     clr_err;
  logic [WIDTH-1:0]         dout;
  logic [WIDTH-1:0]         ras_top;
  logic [$clog2(DEPTH):0]   ras_cnt;
  logic                     ovf;
  logic                     unf;

  modport master (
    output en, op, din, clr_err,
    input  dout, ras_top, ras_cnt, ovf, unf
  );

  modport slave (
    input  en, op, din, clr_err,
    output dout, ras_top, ras_cnt, ovf, unf
  );
endinterface

// File: rtl/pc2_ras.sv
// rtl/pc2_ras.sv - circular return-address stack for pc2
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (clears sp and count only)
//   push_i, din_i : push din_i; when full the oldest entry is overwritten
//   pop_i        : pop the top entry; ignored when empty
//   top_o        : top entry, 0 when empty
//   cnt_o        : number of valid entries, 0..DEPTH
//   full_o, empty_o : count at DEPTH / at 0
module pc2_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       top_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign top_idx = sp_q - PTR_W'(1);
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  // sp always points at the next free slot. When full, that slot holds the
  // oldest entry, so a push there overwrites it while DEPTH being a power
  // of two lets sp wrap for free.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      sp_d = sp_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage has no reset: a reset only forgets entries by zeroing the count.
  always_ff @(posedge clk) begin
    if (reset_n && push_i) mem_q[sp_q] <= din_i;
  end
endmodule

// File: rtl/pc2.sv
// rtl/pc2.sv - program counter with jump, relative branch and return-address stack
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset; loads RESET_ADDR, empties the RAS, clears flags
//   bus     : pc2_if.slave carrying en/op/din/clr_err in and dout/ras_top/ras_cnt/ovf/unf out
module pc2
  import pc2_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input logic  clk,
  input logic  reset_n,
  pc2_if.slave bus
);
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, ovf_evt, unf_evt;
  logic             ras_full, ras_empty;
  pc_op_e           op;

  assign op     = pc_op_e'(bus.op);
  assign pc_inc = pc_q + WIDTH'(1);

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (bus.en) begin
      case (op)
        PC_INC:  pc_d = pc_inc;
        PC_JMP:  pc_d = bus.din;
        // Two's complement add modulo 2^WIDTH is a plain unsigned add.
        PC_BRA:  pc_d = pc_q + bus.din;
        PC_CALL: begin
          pc_d    = bus.din;
          push    = 1'b1;
          ovf_evt = ras_full;
        end
        PC_RET: begin
          if (ras_empty) begin
            pc_d    = pc_inc;
            unf_evt = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // Set-dominant sticky flags; clr_err acts even when en is low.
  always_comb begin
    ovf_d = ovf_evt ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
    unf_d = unf_evt ? 1'b1 : (bus.clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc2_ras #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .top_o   (ras_top),
    .cnt_o   (bus.ras_cnt),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  assign bus.dout    = pc_q;
  assign bus.ras_top = ras_top;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
endmodule

// File: tb/tb_pc2.sv
// tb/tb_pc2.sv - directed self-checking bench for pc2
module tb_pc2;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  pc2_if #(.WIDTH(32), .DEPTH(8)) bus ();

  pc2 #(
    .WIDTH      (32),
    .DEPTH      (8),
    .RESET_ADDR (32'h100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs; sampling happens 1 time unit later.
  task automatic step(input logic e, input logic [2:0] o, input logic [31:0] d, input logic c);
    bus.en      = e;
    bus.op      = o;
    bus.din     = d;
    bus.clr_err = c;
    @(posedge clk);
    #1;
    bus.en      = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.en = 1'b0; bus.op = 3'd0; bus.din = '0; bus.clr_err = 1'b0;

    // Reset
    step(1'b1, 3'd1, 32'h0, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b0);
    chk("reset_dout", bus.dout, 32'h100);
    chk("reset_cnt", 32'(bus.ras_cnt), 32'd0);
    chk("reset_top", bus.ras_top, 32'h0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    chk("reset_unf", 32'(bus.unf), 32'd0);
    reset_n = 1'b1;

    // Increment and enable hold
    step(1'b1, 3'd1, 32'h0, 1'b0); chk("inc1", bus.dout, 32'h101);
    step(1'b1, 3'd1, 32'h0, 1'b0); chk("inc2", bus.dout, 32'h102);
    step(1'b1, 3'd1, 32'h0, 1'b0); chk("inc3", bus.dout, 32'h103);
    step(1'b0, 3'd1, 32'h0, 1'b0);
    step(1'b0, 3'd2, 32'h55, 1'b0); chk("en_hold", bus.dout, 32'h103);

    // Branch and wrap
    step(1'b1, 3'd3, 32'hFFFF_FFFE, 1'b0); chk("bra_neg2", bus.dout, 32'h101);
    step(1'b1, 3'd3, 32'h0000_0010, 1'b0); chk("bra_pos", bus.dout, 32'h111);
    step(1'b1, 3'd2, 32'hFFFF_FFFF, 1'b0); chk("jmp_max", bus.dout, 32'hFFFF_FFFF);
    step(1'b1, 3'd1, 32'h0, 1'b0);         chk("inc_wrap", bus.dout, 32'h0);
    step(1'b1, 3'd0, 32'h77, 1'b0);        chk("hold", bus.dout, 32'h0);
    step(1'b1, 3'd7, 32'h77, 1'b0);        chk("op7", bus.dout, 32'h0);
    step(1'b1, 3'd6, 32'h77, 1'b0);        chk("op6", bus.dout, 32'h0);

    // Call / return nesting
    step(1'b1, 3'd2, 32'h10, 1'b0);
    step(1'b1, 3'd4, 32'h40, 1'b0);
    chk("call1_dout", bus.dout, 32'h40);
    chk("call1_top", bus.ras_top, 32'h11);
    step(1'b1, 3'd4, 32'h80, 1'b0);
    chk("call2_dout", bus.dout, 32'h80);
    chk("call2_cnt", 32'(bus.ras_cnt), 32'd2);
    chk("call2_top", bus.ras_top, 32'h41);
    step(1'b1, 3'd5, 32'h0, 1'b0);
    chk("ret1_dout", bus.dout, 32'h41);
    chk("ret1_cnt", 32'(bus.ras_cnt), 32'd1);
    step(1'b1, 3'd5, 32'h0, 1'b0);
    chk("ret2_dout", bus.dout, 32'h11);
    chk("ret2_cnt", 32'(bus.ras_cnt), 32'd0);
    chk("ret2_top", bus.ras_top, 32'h0);

    // Overflow: calls from PCs 0..8, each to PC+1, push return addresses 1..9
    step(1'b1, 3'd2, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 3'd4, 32'(i + 1), 1'b0);
      if (i == 7) begin
        chk("full_cnt", 32'(bus.ras_cnt), 32'd8);
        chk("full_no_ovf", 32'(bus.ovf), 32'd0);
      end
    end
    chk("ovf_cnt", 32'(bus.ras_cnt), 32'd8);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    chk("ovf_top", bus.ras_top, 32'h9);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd5, 32'h0, 1'b0);
      chk($sformatf("ovf_ret%0d", i), bus.dout, 32'(9 - i));
    end
    chk("drain_cnt", 32'(bus.ras_cnt), 32'd0);
    chk("drain_unf", 32'(bus.unf), 32'd0);
    step(1'b1, 3'd5, 32'h0, 1'b0);
    chk("unf_set", 32'(bus.unf), 32'd1);
    chk("unf_dout", bus.dout, 32'h3);
    chk("unf_cnt", 32'(bus.ras_cnt), 32'd0);

    // Flag clearing
    step(1'b0, 3'd5, 32'h0, 1'b1);
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    chk("clr_unf", 32'(bus.unf), 32'd0);
    chk("clr_dout", bus.dout, 32'h3);
    step(1'b1, 3'd5, 32'h0, 1'b1);
    chk("collide_unf", 32'(bus.unf), 32'd1);
    chk("collide_dout", bus.dout, 32'h4);

    // Mid-sequence reset with 3 entries pushed and PC=0x200
    step(1'b1, 3'd4, 32'h1F0, 1'b0);
    step(1'b1, 3'd4, 32'h1F8, 1'b0);
    step(1'b1, 3'd4, 32'h200, 1'b0);
    chk("pre_rst_dout", bus.dout, 32'h200);
    chk("pre_rst_cnt", 32'(bus.ras_cnt), 32'd3);
    reset_n = 1'b0;
    step(1'b1, 3'd4, 32'h300, 1'b1);
    reset_n = 1'b1;
    chk("rst_dout", bus.dout, 32'h100);
    chk("rst_cnt", 32'(bus.ras_cnt), 32'd0);
    chk("rst_top", bus.ras_top, 32'h0);
    chk("rst_unf", 32'(bus.unf), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    step(1'b1, 3'd5, 32'h0, 1'b0);
    chk("post_rst_unf", 32'(bus.unf), 32'd1);
    chk("post_rst_dout", bus.dout, 32'h101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
